// File: rtl/dmem_sized_if.sv
// Request/response bus between the MEM stage and dmem_sized; master drives requests, slave answers.
// One request in flight; the requester holds its request while req_ready is low.
interface dmem_sized_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/dmem_sized.sv
// Big-endian byte/half/word data memory; store/error respond 1 cycle after accept, loads after 1+WAIT_STATES.
// req_ready is high only in IDLE; DMEM_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module dmem_sized #(
    parameter int unsigned SIZE        = 32'h8000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_sized_if.slave  bus
);
    localparam int unsigned AW = $clog2(SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   addr_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [31:0]     resp_rdata_q;

    logic [7:0]      mem [SIZE];

    logic            accept;
    logic [2:0]      req_nbytes;
    logic [32:0]     last_byte;
    logic            size_err;
    logic            range_err;
    logic            align_err;
    logic            req_err;
    logic [31:0]     wdata_lj;

    logic [AW-1:0]   rd_addr;
    logic [1:0]      rd_size;
    logic            rd_uns;
    logic [2:0]      rd_nbytes;
    logic [31:0]     load_raw;
    logic [31:0]     load_data;

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        req_nbytes = 3'd4;
        case (bus.req_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
    end

    // 33-bit end address so an access near 2^32 cannot wrap back into range
    assign last_byte = {1'b0, bus.req_addr} + {30'b0, req_nbytes} - 33'd1;
    assign range_err = (last_byte >= 33'(SIZE));
    assign size_err  = (bus.req_size == 2'b11);

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif

    assign req_err = size_err || range_err || align_err;

    // left-justify store data so byte n of the access is always wdata_lj[31-8n -: 8]
    always_comb begin
        wdata_lj = bus.req_wdata;
        case (bus.req_size)
            2'b00:   wdata_lj = {bus.req_wdata[7:0], 24'b0};
            2'b01:   wdata_lj = {bus.req_wdata[15:0], 16'b0};
            default: wdata_lj = bus.req_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept && bus.req_write && !req_err) begin
            for (int n = 0; n < 4; n++) begin
                if (3'(n) < req_nbytes) begin
                    mem[bus.req_addr[AW-1:0] + AW'(n)] <= wdata_lj[8*(3-n) +: 8];
                end
            end
        end
    end

    // zero-wait loads read with the live request, delayed loads with the captured one
    assign rd_addr = (state_q == S_IDLE) ? bus.req_addr[AW-1:0] : addr_q;
    assign rd_size = (state_q == S_IDLE) ? bus.req_size         : size_q;
    assign rd_uns  = (state_q == S_IDLE) ? bus.req_unsigned     : uns_q;

    always_comb begin
        rd_nbytes = 3'd4;
        case (rd_size)
            2'b00:   rd_nbytes = 3'd1;
            2'b01:   rd_nbytes = 3'd2;
            default: rd_nbytes = 3'd4;
        endcase
    end

    always_comb begin
        load_raw = 32'b0;
        for (int n = 0; n < 4; n++) begin
            if (3'(n) < rd_nbytes) begin
                load_raw = {load_raw[23:0], mem[rd_addr + AW'(n)]};
            end
        end
    end

    always_comb begin
        load_data = load_raw;
        case (rd_size)
            2'b00:   load_data = rd_uns ? {24'b0, load_raw[7:0]}
                                        : {{24{load_raw[7]}}, load_raw[7:0]};
            2'b01:   load_data = rd_uns ? {16'b0, load_raw[15:0]}
                                        : {{16{load_raw[15]}}, load_raw[15:0]};
            default: load_data = load_raw;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q <= bus.req_addr[AW-1:0];
                        size_q <= bus.req_size;
                        uns_q  <= bus.req_unsigned;
                        if (req_err || bus.req_write) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= req_err;
                            resp_rdata_q <= 32'b0;
                        end else if (WAIT_STATES == 0) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= load_data;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'b0;
                end
            endcase
        end
    end
endmodule
